// File: rtl/phs_arbiter_pkg.sv
// Shared parser summary types plus the source tag used by the N3/N6 scheduler.
package phs_arbiter_pkg;

  typedef struct packed {
    logic [31:0] src_ip;
    logic [31:0] dst_ip;
    logic [15:0] src_port;
    logic [15:0] dst_port;
    logic [7:0]  protocol;
    logic [7:0]  incoming_interface;
    logic [7:0]  qfi;
  } PHS_Struct;

  typedef enum logic {SRC_N3, SRC_N6} PHS_SRC;

  localparam int PHS_W = $bits(PHS_Struct);

  function automatic PHS_Struct set_if_id(PHS_Struct s, logic [7:0] id);
    PHS_Struct r;
    r = s;
    r.incoming_interface = id;
    return r;
  endfunction

endpackage

// File: rtl/phs_fifo.sv
// Small synchronous FIFO; level is derived from wrap-around pointers with an extra MSB.
module phs_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 120
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [W-1:0]             wdata,
  input  logic                     push,
  input  logic                     pop,
  output logic [W-1:0]             head,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     ready
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr_reg;
  logic [AW:0]  rd_ptr_reg;
  logic         accept;

  assign level  = wr_ptr_reg - rd_ptr_reg;
  // Ready looks only at the registered level, never at a same-cycle pop.
  assign ready  = !rst && (level < (AW+1)'(DEPTH));
  assign accept = push && ready;
  assign head   = mem[rd_ptr_reg[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (accept) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)    rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr_reg[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/phs_arbiter.sv
// Weighted round-robin scheduler sharing one PHS consumer between the N3 and N6 parsers.
module phs_arbiter
  import phs_arbiter_pkg::*;
#(
  parameter int         FIFO_DEPTH = 4,
  parameter int         N3_WEIGHT  = 2,
  parameter int         N6_WEIGHT  = 1,
  parameter logic [7:0] N3_IF_ID   = 8'h00,
  parameter logic [7:0] N6_IF_ID   = 8'h01
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [PHS_W-1:0]              n3_phs_i,
  input  logic                          n3_valid_i,
  output logic                          n3_ready_o,
  input  logic [PHS_W-1:0]              n6_phs_i,
  input  logic                          n6_valid_i,
  output logic                          n6_ready_o,
  output logic [PHS_W-1:0]              phs_o,
  output logic                          src_o,
  output logic                          valid_o,
  input  logic                          ready_i,
  output logic [$clog2(FIFO_DEPTH):0]   n3_level_o,
  output logic [$clog2(FIFO_DEPTH):0]   n6_level_o
);
  localparam int         LW    = $clog2(FIFO_DEPTH) + 1;
  localparam logic [3:0] N3_W4 = 4'(N3_WEIGHT);
  localparam logic [3:0] N6_W4 = 4'(N6_WEIGHT);

  // Index 0 is N3, index 1 is N6, matching the PHS_SRC encoding.
  logic [PHS_W-1:0] in_phs   [2];
  logic             in_valid [2];
  logic [PHS_W-1:0] head     [2];
  logic [LW-1:0]    level    [2];
  logic             rdy      [2];
  logic             pop      [2];
  logic             nonempty [2];

  assign in_phs[0]   = n3_phs_i;
  assign in_phs[1]   = n6_phs_i;
  assign in_valid[0] = n3_valid_i;
  assign in_valid[1] = n6_valid_i;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_fifo
      phs_fifo #(.DEPTH(FIFO_DEPTH), .W(PHS_W)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .wdata (in_phs[gi]),
        .push  (in_valid[gi]),
        .pop   (pop[gi]),
        .head  (head[gi]),
        .level (level[gi]),
        .ready (rdy[gi])
      );
      assign nonempty[gi] = (level[gi] != '0);
    end
  endgenerate

  assign n3_ready_o = rdy[0];
  assign n6_ready_o = rdy[1];
  assign n3_level_o = level[0];
  assign n6_level_o = level[1];

  PHS_SRC           cur_port_reg, cur_port_next, gnt_port, other_port;
  logic [3:0]       burst_cnt_reg, burst_cnt_next, weight;
  logic             valid_reg, src_reg, load, grant;
  logic [PHS_W-1:0] phs_reg, gnt_phs;

  assign load    = !valid_reg || ready_i;
  assign valid_o = valid_reg;
  assign phs_o   = phs_reg;
  assign src_o   = src_reg;

  always_comb begin
    cur_port_next  = cur_port_reg;
    burst_cnt_next = burst_cnt_reg;
    other_port     = (cur_port_reg == SRC_N3) ? SRC_N6 : SRC_N3;
    weight         = (cur_port_reg == SRC_N3) ? N3_W4 : N6_W4;
    gnt_port       = SRC_N3;
    pop[0]         = 1'b0;
    pop[1]         = 1'b0;

    if (nonempty[0] && nonempty[1])
      gnt_port = (burst_cnt_reg < weight) ? cur_port_reg : other_port;
    else if (nonempty[1])
      gnt_port = SRC_N6;

    grant = load && (nonempty[0] || nonempty[1]);

    if (grant) begin
      pop[0] = (gnt_port == SRC_N3);
      pop[1] = (gnt_port == SRC_N6);
      if (gnt_port == cur_port_reg) begin
        if (burst_cnt_reg != 4'hF) burst_cnt_next = burst_cnt_reg + 4'd1;
      end else begin
        cur_port_next  = gnt_port;
        burst_cnt_next = 4'd1;
      end
    end

    gnt_phs = (gnt_port == SRC_N3) ? set_if_id(head[0], N3_IF_ID)
                                   : set_if_id(head[1], N6_IF_ID);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_reg     <= 1'b0;
      phs_reg       <= '0;
      src_reg       <= 1'b0;
      cur_port_reg  <= SRC_N3;
      burst_cnt_reg <= '0;
    end else begin
      cur_port_reg  <= cur_port_next;
      burst_cnt_reg <= burst_cnt_next;
      if (load) begin
        valid_reg <= grant;
        if (grant) begin
          phs_reg <= gnt_phs;
          src_reg <= gnt_port;
        end
      end
    end
  end

endmodule

// File: tb/tb_phs_arbiter.sv
// Scoreboard bench for phs_arbiter: directed stimulus with hand-ordered expected grants.
module tb_phs_arbiter;
  import phs_arbiter_pkg::*;

  logic             clk = 1'b0;
  logic             rst;
  logic [PHS_W-1:0] n3_phs_i, n6_phs_i, phs_o;
  logic             n3_valid_i, n6_valid_i, n3_ready_o, n6_ready_o;
  logic             src_o, valid_o, ready_i;
  logic [2:0]       n3_level_o, n6_level_o;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [PHS_W-1:0] phs;
    logic             src;
  } exp_t;
  exp_t sb[$];

  phs_arbiter dut (
    .clk(clk), .rst(rst),
    .n3_phs_i(n3_phs_i), .n3_valid_i(n3_valid_i), .n3_ready_o(n3_ready_o),
    .n6_phs_i(n6_phs_i), .n6_valid_i(n6_valid_i), .n6_ready_o(n6_ready_o),
    .phs_o(phs_o), .src_o(src_o), .valid_o(valid_o), .ready_i(ready_i),
    .n3_level_o(n3_level_o), .n6_level_o(n6_level_o)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  task automatic check(string name, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Input beat for a port; incoming_interface carries junk the DUT must overwrite.
  function automatic PHS_Struct mk(bit port, int idx);
    PHS_Struct s;
    s.src_ip             = 32'hC0A8_0000 + 32'(idx) + (port ? 32'h100 : 32'h0);
    s.dst_ip             = 32'h0A00_0000 + 32'(idx * 3);
    s.src_port           = 16'd1000 + 16'(idx);
    s.dst_port           = port ? 16'd443 + 16'(idx) : 16'd2152 + 16'(idx);
    s.protocol           = port ? 8'd6 : 8'd17;
    s.incoming_interface = 8'h5A;
    s.qfi                = 8'(idx);
    return s;
  endfunction

  task automatic exp_push(bit port, int idx);
    exp_t e;
    PHS_Struct s;
    s = mk(port, idx);
    s.incoming_interface = port ? 8'h01 : 8'h00;
    e.phs = s;
    e.src = port;
    sb.push_back(e);
  endtask

  task automatic send_n3(int n, int base);
    for (int i = 0; i < n; i++) begin
      int t;
      n3_phs_i   = mk(1'b0, base + i);
      n3_valid_i = 1'b1;
      t = 0;
      do begin
        @(negedge clk);
        t++;
      end while (!n3_ready_o && t < 300);
      if (!n3_ready_o) begin
        checks++; errors++;
        $display("FAIL n3_send_timeout: beat %0d never accepted, ready=%b required 1", base + i, n3_ready_o);
        n3_valid_i = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    n3_valid_i = 1'b0;
  endtask

  task automatic send_n6(int n, int base);
    for (int i = 0; i < n; i++) begin
      int t;
      n6_phs_i   = mk(1'b1, base + i);
      n6_valid_i = 1'b1;
      t = 0;
      do begin
        @(negedge clk);
        t++;
      end while (!n6_ready_o && t < 300);
      if (!n6_ready_o) begin
        checks++; errors++;
        $display("FAIL n6_send_timeout: beat %0d never accepted, ready=%b required 1", base + i, n6_ready_o);
        n6_valid_i = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    n6_valid_i = 1'b0;
  endtask

  task automatic wait_drain(string name);
    int t = 0;
    while (!(sb.size() == 0 && !valid_o) && t < 300) begin
      @(negedge clk);
      t++;
    end
    check(name, 128'(sb.size() == 0 && !valid_o), 128'(1));
  endtask

  // Monitor: every accepted output beat is popped from the scoreboard and compared.
  always @(negedge clk) begin
    if (!rst && valid_o && ready_i) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL out_unexpected: got src=%0d phs=%h, required no output", src_o, phs_o);
      end else begin
        exp_t e;
        e = sb.pop_front();
        $display("OUT src=%0d phs=%h", src_o, phs_o);
        check("out_phs", 128'(phs_o), 128'(e.phs));
        check("out_src", 128'(src_o), 128'(e.src));
      end
    end
  end

  initial begin
    PHS_Struct o;
    int run;
    int order [12] = '{0, 0, 1, 0, 0, 1, 0, 0, 1, 1, 1, 1};
    int i3, i6;

    rst = 1'b1; ready_i = 1'b0;
    n3_valid_i = 1'b0; n6_valid_i = 1'b0;
    n3_phs_i = '0; n6_phs_i = '0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_valid", 128'(valid_o), 128'(0));
    check("rst_phs", 128'(phs_o), 128'(0));
    check("rst_src", 128'(src_o), 128'(0));
    check("rst_n3_level", 128'(n3_level_o), 128'(0));
    check("rst_n6_level", 128'(n6_level_o), 128'(0));
    check("rst_n3_ready", 128'(n3_ready_o), 128'(0));
    check("rst_n6_ready", 128'(n6_ready_o), 128'(0));
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("post_rst_n3_ready", 128'(n3_ready_o), 128'(1));
    check("post_rst_n6_ready", 128'(n6_ready_o), 128'(1));
    @(posedge clk); #1;

    // Single N6 packet, latency and field override
    ready_i = 1'b1;
    exp_push(1'b1, 0);
    send_n6(1, 0);
    @(negedge clk);
    check("lat_not_yet", 128'(valid_o), 128'(0));
    @(negedge clk);
    check("lat_valid", 128'(valid_o), 128'(1));
    o = phs_o;
    check("single_dst_port", 128'(o.dst_port), 128'(16'd443));
    check("single_iface", 128'(o.incoming_interface), 128'(8'h01));
    check("single_src", 128'(src_o), 128'(1));
    wait_drain("single_drain");
    @(posedge clk); #1;

    // Weighted round robin: 6 beats per port preloaded under backpressure
    ready_i = 1'b0;
    i3 = 16; i6 = 16;
    for (int k = 0; k < 12; k++) begin
      if (order[k] == 0) begin exp_push(1'b0, i3); i3++; end
      else               begin exp_push(1'b1, i6); i6++; end
    end
    fork
      send_n3(6, 16);
      send_n6(6, 16);
      begin
        int t = 0;
        while (!(n3_level_o == 3'd4 && n6_level_o == 3'd4) && t < 100) begin
          @(negedge clk);
          t++;
        end
        check("wrr_preload_full", 128'(n3_level_o == 3'd4 && n6_level_o == 3'd4), 128'(1));
        @(posedge clk); #1 ready_i = 1'b1;
      end
    join
    wait_drain("wrr_drain");
    @(posedge clk); #1;

    // Full FIFO / backpressure on N3
    ready_i = 1'b0;
    for (int k = 0; k < 7; k++) exp_push(1'b0, 64 + k);
    fork
      send_n3(7, 64);
      begin
        int t = 0;
        PHS_Struct first;
        first = mk(1'b0, 64);
        first.incoming_interface = 8'h00;
        while (n3_level_o != 3'd4 && t < 100) begin
          @(negedge clk);
          t++;
        end
        check("bp_level_full", 128'(n3_level_o), 128'(4));
        check("bp_ready_drop", 128'(n3_ready_o), 128'(0));
        check("bp_valid_held", 128'(valid_o), 128'(1));
        for (int k = 0; k < 4; k++) begin
          @(negedge clk);
          check("bp_phs_stable", 128'(phs_o), 128'(first));
        end
        check("bp_level_hold", 128'(n3_level_o), 128'(4));
        @(posedge clk); #1 ready_i = 1'b1;
      end
    join
    wait_drain("bp_drain");
    @(posedge clk); #1;

    // Idle N6: ten N3 beats must stream out back-to-back
    for (int k = 0; k < 10; k++) exp_push(1'b0, 96 + k);
    run = 0;
    fork
      send_n3(10, 96);
      begin
        int t = 0;
        while (!valid_o && t < 50) begin
          @(negedge clk);
          t++;
        end
        while (valid_o && run < 20) begin
          run++;
          @(negedge clk);
        end
      end
    join
    check("idle_run_length", 128'(run), 128'(10));
    wait_drain("idle_drain");
    @(posedge clk); #1;

    // Reset mid-operation; N6 wins the first slot since N3's burst is saturated
    ready_i = 1'b0;
    fork
      send_n3(3, 128);
      send_n6(4, 128);
    join
    @(negedge clk);
    check("mid_valid_before", 128'(valid_o), 128'(1));
    check("mid_src_before", 128'(src_o), 128'(1));
    check("mid_n3_level_before", 128'(n3_level_o), 128'(3));
    check("mid_n6_level_before", 128'(n6_level_o), 128'(3));
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("mid_valid_after", 128'(valid_o), 128'(0));
    check("mid_phs_after", 128'(phs_o), 128'(0));
    check("mid_n3_level_after", 128'(n3_level_o), 128'(0));
    check("mid_n6_level_after", 128'(n6_level_o), 128'(0));
    @(posedge clk); #1;
    ready_i = 1'b1;
    exp_push(1'b0, 160);
    exp_push(1'b1, 160);
    fork
      send_n3(1, 160);
      send_n6(1, 160);
    join
    wait_drain("mid_refill_drain");

    check("sb_empty_end", 128'(sb.size()), 128'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/phs_arbiter.md
# phs_arbiter

Two-input scheduler that shares one downstream PHS consumer (rule lookup/classifier) between the N3 (GTP-U) parser and the N6 (IPv4/TCP/UDP) parser. Each parser's `PHS_Struct` output is buffered in a small per-port FIFO and granted by weighted round-robin into a single registered valid/ready output. On grant, the `incoming_interface` field of the summary is overwritten with a per-port ID.

## Interface
Parameters:
- `FIFO_DEPTH`, 4: entries per input FIFO; power of two, ≥2.
- `N3_WEIGHT`, 2: max consecutive N3 grants while N6 is pending; 1..15.
- `N6_WEIGHT`, 1: max consecutive N6 grants while N3 is pending; 1..15.
- `N3_IF_ID`, 8'h00: value written into `incoming_interface` for N3 grants.
- `N6_IF_ID`, 8'h01: value written into `incoming_interface` for N6 grants.

Ports:
- `clk`  in  1  single clock, all state on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `n3_phs_i`  in  120  `PHS_Struct` from N3 parser.
- `n3_valid_i` / `n3_ready_o`  in/out  1  N3 input handshake.
- `n6_phs_i`  in  120  `PHS_Struct` from N6 parser.
- `n6_valid_i` / `n6_ready_o`  in/out  1  N6 input handshake.
- `phs_o`  out  120  granted summary with `incoming_interface` replaced.
- `src_o`  out  1  `PHS_SRC`: 0 = N3, 1 = N6.
- `valid_o` / `ready_i`  out/in  1  output handshake.
- `n3_level_o`, `n6_level_o`  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy.

## Operation
- Input transfer occurs when `valid && ready` on a rising edge. `xx_ready_o = !rst && level < FIFO_DEPTH`, derived from registered level only; it does not depend on same-cycle pops.
- The output stage is one register (`phs_o`, `src_o`, `valid_o`). Its load condition is `load = !valid_o || ready_i`.
- A grant happens when `load` is true and at least one FIFO is non-empty. The granted head is popped and written to the output register in the same edge. `valid_o` is set. If `load` is true and no FIFO is non-empty, `valid_o` is cleared.
- Arbiter state:
  - `cur_port`: reset N3.
  - `burst_cnt`: 4 bits, reset 0.
- Grant selection:
  - If only one FIFO is non-empty, that port is granted.
  - If both are non-empty:
    - Grant `cur_port` if `burst_cnt < WEIGHT[cur_port]`.
    - Otherwise grant the other port.
- After a grant to port p:
  - If p == `cur_port`, `burst_cnt` increments, saturating at 15.
  - Otherwise `cur_port` is set to p and `burst_cnt` is set to 1.
- The output field `incoming_interface` is set to the port's `IF_ID`. All other PHS fields pass unchanged.
- A push to an empty FIFO is not visible to the arbiter until the next cycle; there is no bypass. A push and pop on the same FIFO in the same cycle leaves the level unchanged.
- Input ordering is preserved per port. No ordering is guaranteed across ports.

## Timing
- Reset values:
  - `valid_o` = 0, `phs_o` = 0, `src_o` = 0.
  - Both levels = 0.
  - `n3_ready_o` = `n6_ready_o` = 0 while `rst` is high, and 1 the cycle after `rst` falls.
- Minimum latency: input accepted at edge t, `valid_o` high after edge t+1 (2 cycles).
- Throughput: one grant per cycle while `ready_i` is held high.
- Backpressure: while `valid_o && !ready_i`, `phs_o` and `src_o` hold stable, no pops occur, and FIFOs fill. `ready_o` drops in the cycle where the level equals `FIFO_DEPTH`.
- Reset mid-operation: both FIFOs are flushed, the output is dropped (`valid_o` = 0), and the arbiter returns to N3 with `burst_cnt` = 0. In-flight data is discarded without error.
- Weight boundary: with both ports continuously backlogged, the grant pattern repeats with period `N3_WEIGHT + N6_WEIGHT`.

## Structure
- Additions to the shared parser typedef package:
  - `typedef enum logic {SRC_N3, SRC_N6} PHS_SRC`.
  - `localparam int PHS_W = $bits(PHS_Struct)` (= 120).
- Sub-module `phs_fifo` (params `DEPTH`, `W`):
  - Synchronous FIFO with registered level and head read.
  - Wrap-around read/write pointers using the extra MSB.
  - Instantiated once per input.
- Top level contains the arbiter state, the output register and the field override.

## Test plan
- **Single packet:** one N6 beat with `dst_port` = 16'd443, `ready_i` = 1.
  - `valid_o` rises 2 cycles after acceptance.
  - `src_o` = 1, `incoming_interface` = 8'h01, all other fields unchanged.
- **Weighted RR:** 6 beats preloaded per port with `ready_i` = 0, then `ready_i` held at 1.
  - Grant order is N3,N3,N6,N3,N3,N6,N3,N3,N6, followed by the remaining three N6 beats in order.
- **Full FIFO / backpressure:** `ready_i` = 0 and N3 driven continuously.
  - 1 beat sits in the output register and 4 fill the FIFO.
  - `n3_ready_o` falls when `n3_level_o` = 4.
  - `phs_o` stays stable; no beat is lost or duplicated after release.
- **Idle port:** only N3 traffic, 10 beats back-to-back.
  - All 10 are granted consecutively despite `N3_WEIGHT` = 2.
  - `burst_cnt` saturates without a grant glitch.
- **Reset mid-operation:** `rst` pulsed for 1 cycle with 3 beats queued per port and `valid_o` = 1.
  - The next cycle shows `valid_o` = 0 and levels = 0.
  - The first grant after reset goes to N3 when both ports are refilled simultaneously.
